// File: rtl/axis_frame_monitor.sv
// AXI4-Stream sink for the XGS capture output: applies a programmable backpressure
// pattern, checks SOF/SOL/EOL/EOF framing and line lengths, and publishes per-frame status.
module axis_frame_monitor #(
  parameter int          DATA_WIDTH = 64,
  parameter int          USER_WIDTH = 4,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  aclk,
  input  logic                  aclk_reset_n,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic [1:0]            cfg_bp_mode,
  input  logic                  cfg_clear,
  output logic                  frame_done,
  output logic [31:0]           frame_cnt,
  output logic [CNT_WIDTH-1:0]  frame_lines,
  output logic [CNT_WIDTH-1:0]  frame_line_beats,
  output logic [31:0]           frame_checksum,
  output logic [3:0]            err_flags,
  output logic [1:0]            dbg_state
);

  // Handshake: a beat transfers on a rising edge where s_axis_tvalid and s_axis_tready
  // are both high; tready is registered and never looks at tvalid, the source must hold
  // tdata/tuser/tlast stable while tvalid is high and tready is low.

  localparam int NWORDS = DATA_WIDTH / 32;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IN_LINE = 2'd1,
    ST_BETWEEN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]  line_cnt_q, line_cnt_d;
  logic [CNT_WIDTH-1:0]  ref_beats_q, ref_beats_d;
  logic [31:0]           csum_q, csum_d;
  logic                  frame_done_q, frame_done_d;
  logic [31:0]           frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0]  frame_lines_q, frame_lines_d;
  logic [CNT_WIDTH-1:0]  frame_line_beats_q, frame_line_beats_d;
  logic [31:0]           frame_checksum_q, frame_checksum_d;
  logic [3:0]            err_q, err_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic                  toggle_q, toggle_d;
  logic                  tready_q, tready_d;

  logic                  accept;
  logic                  sof, eof, sol, eol;
  logic                  take, restart;
  logic [CNT_WIDTH-1:0]  base_beats, base_lines, new_beats;
  logic [31:0]           base_csum, new_csum;

  function automatic logic [31:0] fold_words(input logic [DATA_WIDTH-1:0] d);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < NWORDS; i++) begin
      acc = acc ^ d[i*32 +: 32];
    end
    return acc;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign accept = s_axis_tvalid & tready_q;
  assign sof    = s_axis_tuser[0];
  assign eof    = s_axis_tuser[1];
  assign sol    = s_axis_tuser[2];
  assign eol    = s_axis_tuser[3];

  always_comb begin
    state_d            = state_q;
    beat_cnt_d         = beat_cnt_q;
    line_cnt_d         = line_cnt_q;
    ref_beats_d        = ref_beats_q;
    csum_d             = csum_q;
    frame_done_d       = 1'b0;
    frame_cnt_d        = frame_cnt_q;
    frame_lines_d      = frame_lines_q;
    frame_line_beats_d = frame_line_beats_q;
    frame_checksum_d   = frame_checksum_q;
    err_d              = err_q;
    take               = 1'b0;
    restart            = 1'b0;
    base_beats         = beat_cnt_q;
    base_lines         = line_cnt_q;
    base_csum          = csum_q;
    new_beats          = '0;
    new_csum           = '0;

    // Backpressure sequencing runs every cycle, independent of traffic and clear.
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    toggle_d = ~toggle_q;
    case (cfg_bp_mode)
      2'd0:    tready_d = 1'b1;
      2'd1:    tready_d = toggle_q;
      2'd2:    tready_d = lfsr_q[0];
      default: tready_d = 1'b0;
    endcase

    if (cfg_clear) begin
      state_d            = ST_IDLE;
      beat_cnt_d         = '0;
      line_cnt_d         = '0;
      ref_beats_d        = '0;
      csum_d             = '0;
      frame_cnt_d        = '0;
      frame_lines_d      = '0;
      frame_line_beats_d = '0;
      frame_checksum_d   = '0;
      err_d              = '0;
    end else if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (sof && sol) begin
            take    = 1'b1;
            restart = 1'b1;
          end else begin
            err_d[0] = 1'b1;
          end
        end
        ST_IN_LINE: begin
          take = 1'b1;
          if (sof) begin
            err_d[1] = 1'b1;
            restart  = 1'b1;
          end
        end
        ST_BETWEEN: begin
          if (sof) begin
            err_d[1] = 1'b1;
            take     = 1'b1;
            restart  = 1'b1;
          end else if (sol) begin
            take = 1'b1;
          end else begin
            err_d[0] = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (take) begin
        // A (re)starting beat is processed as the first beat of a fresh frame.
        if (restart) begin
          base_beats = '0;
          base_lines = '0;
          base_csum  = '0;
        end
        new_beats = sat_inc(base_beats);
        new_csum  = base_csum + fold_words(s_axis_tdata);
        csum_d    = new_csum;
        if ((eol != s_axis_tlast) || (eof && !eol)) begin
          err_d[2] = 1'b1;
        end
        if (eol || eof) begin
          if (base_lines == '0) begin
            ref_beats_d = new_beats;
          end else if (new_beats != ref_beats_q) begin
            err_d[3] = 1'b1;
          end
          line_cnt_d = sat_inc(base_lines);
          beat_cnt_d = '0;
          if (eof) begin
            frame_lines_d      = sat_inc(base_lines);
            frame_line_beats_d = (base_lines == '0) ? new_beats : ref_beats_q;
            frame_checksum_d   = new_csum;
            frame_cnt_d        = frame_cnt_q + 32'd1;
            frame_done_d       = 1'b1;
            state_d            = ST_IDLE;
          end else begin
            state_d = ST_BETWEEN;
          end
        end else begin
          beat_cnt_d = new_beats;
          line_cnt_d = base_lines;
          state_d    = ST_IN_LINE;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aclk_reset_n) begin
      state_q            <= ST_IDLE;
      beat_cnt_q         <= '0;
      line_cnt_q         <= '0;
      ref_beats_q        <= '0;
      csum_q             <= '0;
      frame_done_q       <= 1'b0;
      frame_cnt_q        <= '0;
      frame_lines_q      <= '0;
      frame_line_beats_q <= '0;
      frame_checksum_q   <= '0;
      err_q              <= '0;
      lfsr_q             <= LFSR_SEED;
      toggle_q           <= 1'b1;
      tready_q           <= 1'b0;
    end else begin
      state_q            <= state_d;
      beat_cnt_q         <= beat_cnt_d;
      line_cnt_q         <= line_cnt_d;
      ref_beats_q        <= ref_beats_d;
      csum_q             <= csum_d;
      frame_done_q       <= frame_done_d;
      frame_cnt_q        <= frame_cnt_d;
      frame_lines_q      <= frame_lines_d;
      frame_line_beats_q <= frame_line_beats_d;
      frame_checksum_q   <= frame_checksum_d;
      err_q              <= err_d;
      lfsr_q             <= lfsr_d;
      toggle_q           <= toggle_d;
      tready_q           <= tready_d;
    end
  end

  assign s_axis_tready    = tready_q;
  assign frame_done       = frame_done_q;
  assign frame_cnt        = frame_cnt_q;
  assign frame_lines      = frame_lines_q;
  assign frame_line_beats = frame_line_beats_q;
  assign frame_checksum   = frame_checksum_q;
  assign err_flags        = err_q;
  assign dbg_state        = state_q;

endmodule
